alarm_scan_ctrl: RTL and testbench
==================================

# alarm_scan_ctrl

Four-channel scheduler that shares one peak-to-peak threshold comparator among the vibration-detect channels. Each channel's peak/valley extractor offers a peak/valley pair with a valid/ready handshake. The block grants channels round-robin, computes the peak-to-peak amplitude and keeps a per-channel consecutive-over-line counter. It drives per-channel alarm levels and serializes alarm assert/clear events to the downstream reporter over a second valid/ready handshake.

## Interface
- ALARM_LINE, 16'h8000, peak-to-peak threshold (unsigned)
- OVER_COUNT, 8'd10, consecutive over-line samples needed to raise an alarm (legal range 1..255)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pv_valid  in  4  per-channel pair valid; held by source until accepted
- pv_ready  out  4  one-hot accept strobe, registered
- peak_data  in  64  channel i peak at [16i+15:16i], unsigned
- valley_data  in  64  channel i valley at [16i+15:16i], unsigned
- alarm_level  out  4  per-channel alarm state, registered
- evt_valid  out  1  event pending to reporter
- evt_ch  out  2  channel of pending event
- evt_type  out  1  1 = alarm raised, 0 = alarm cleared
- evt_ready  in  1  reporter accepts event

## Operation
- FSM states: IDLE, CAP, CMP, EVT.
- IDLE:
  - If any pv_valid is set, select grant g. Search starts at rr_ptr and ascends modulo 4; the first set bit wins.
  - Set pv_ready to one-hot g and go to CAP.
  - Otherwise stay in IDLE.
- CAP:
  - pv_ready[g] is high for exactly this cycle.
  - At the end of the cycle, latch peak_data[g] and valley_data[g]. pv_valid[g] is high by source contract.
  - Set rr_ptr to (g+1) mod 4, then go to CMP.
- CMP: diff = peak − valley when peak ≥ valley; diff = 0 otherwise (no wrap-around).
  - diff ≥ ALARM_LINE: cnt[g] = min(cnt[g]+1, 255).
  - diff < ALARM_LINE: cnt[g] = 0.
  - New level: 1 if the updated cnt[g] ≥ OVER_COUNT, else 0.
  - alarm_level[g] takes the new level at the end of CMP.
  - Level changed: load evt_ch = g and evt_type = new level, then go to EVT.
  - Level unchanged: go to IDLE.
- EVT:
  - evt_valid = 1. evt_ch and evt_type stay stable until evt_valid && evt_ready.
  - Then evt_valid drops and the FSM returns to IDLE.
  - No new grants occur while in EVT.
- Counters: 8-bit per channel and saturating. A counter is only touched while its own channel is granted.
- Reset values: state = IDLE, rr_ptr = 0, all cnt = 0, pv_ready = 0, alarm_level = 0, evt_valid = 0, evt_ch = 0, evt_type = 0.
- Reset mid-operation: all of the above clear immediately. Any pair in flight is dropped and any pending event is lost; no replay.

## Timing
- Sample with no event: 3 cycles (IDLE→CAP→CMP→IDLE). Peak throughput is one pair per 3 cycles.
- alarm_level[g] updates on the clock edge ending CMP, i.e. 2 edges after the edge at which IDLE moved to CAP.
- evt_valid rises in the cycle after CMP.
  - With evt_ready held high, the event completes in 1 cycle and IDLE is re-entered the next cycle.
- evt_ready has no effect outside EVT.
- Simultaneous valid on several channels: grant order follows rr_ptr. No channel waits longer than 3 other grants.
- pv_valid dropped during CAP is a source protocol violation. The block still captures the data.
- alarm_level is sticky between a channel's samples.
- With OVER_COUNT = 1, a single over-line sample raises the alarm.

## Test plan
- Reset, then all pv_valid = 0 for 20 cycles → pv_ready, alarm_level and evt_valid stay 0.
- Ch0 only, 10 pairs with peak = 16'hC000, valley = 16'h1000 (diff 0xB000) → alarm_level[0] = 0 after pair 9, = 1 after pair 10; exactly one event {ch 0, type 1}.
- Then ch0 pair peak = 16'h5000, valley = 16'h4000 → cnt[0] = 0, alarm_level[0] = 0, event {ch 0, type 0}.
- Ch2 pair peak = 16'h1000, valley = 16'hF000 → diff = 0; no alarm and no event.
- All 4 pv_valid held high with rr_ptr = 0 → grant order 0, 1, 2, 3, 0, each pv_ready a 1-cycle one-hot pulse, 3 cycles apart.
- Ch1 raises an alarm with evt_ready = 0 for 7 cycles and ch3 valid → evt_valid held with stable fields and no ch3 pv_ready until the handshake completes.
- Separately, assert rst low during EVT → all outputs and counters return to 0 asynchronously.

Source files
------------

// File: rtl/alarm_scan_ctrl.sv
// alarm_scan_ctrl: round-robin shared peak-to-peak comparator with per-channel alarm levels and event serializer
module alarm_scan_ctrl #(
   parameter logic [15:0] ALARM_LINE = 16'h8000,
   parameter logic [7:0]  OVER_COUNT = 8'd10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pv_valid,
   output logic [3:0]  pv_ready,
   input  logic [63:0] peak_data,
   input  logic [63:0] valley_data,
   output logic [3:0]  alarm_level,
   output logic        evt_valid,
   output logic [1:0]  evt_ch,
   output logic        evt_type,
   input  logic        evt_ready
);
   typedef enum logic [1:0] {IDLE, CAP, CMP, EVT} state_t;
   state_t      state, state_nxt;
   logic [1:0]  rr_ptr, g, g_sel, idx;
   logic [15:0] peak_q, valley_q, diff;
   logic [7:0]  cnt [4];
   logic [7:0]  cnt_new;
   logic        lvl_new;
   // descending scan so the lowest offset from rr_ptr wins
   always_comb begin
      g_sel = rr_ptr;
      idx = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr + 2'(k);
         g_sel = pv_valid[idx] ? idx : g_sel;
      end
   end
   always_comb begin
      diff = (peak_q >= valley_q) ? peak_q - valley_q : 16'd0;
      cnt_new = (diff < ALARM_LINE) ? 8'd0 : (cnt[g] == 8'hFF) ? 8'hFF : cnt[g] + 8'd1;
      lvl_new = cnt_new >= OVER_COUNT;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = |pv_valid ? CAP : IDLE;
         CAP:     state_nxt = CMP;
         CMP:     state_nxt = (lvl_new != alarm_level[g]) ? EVT : IDLE;
         EVT:     state_nxt = evt_ready ? IDLE : EVT;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      evt_valid = state == EVT;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= 2'd0;
         g <= 2'd0;
         pv_ready <= 4'd0;
         peak_q <= 16'd0;
         valley_q <= 16'd0;
         alarm_level <= 4'd0;
         evt_ch <= 2'd0;
         evt_type <= 1'b0;
         for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
      end else begin
         pv_ready <= 4'd0;
         if (state == IDLE && |pv_valid) begin
            g <= g_sel;
            pv_ready <= 4'd1 << g_sel;
         end
         if (state == CAP) begin
            peak_q <= peak_data[{g, 4'b0} +: 16];
            valley_q <= valley_data[{g, 4'b0} +: 16];
            rr_ptr <= g + 2'd1;
         end
         if (state == CMP) begin
            cnt[g] <= cnt_new;
            alarm_level[g] <= lvl_new;
            if (lvl_new != alarm_level[g]) begin
               evt_ch <= g;
               evt_type <= lvl_new;
            end
         end
      end
   end
endmodule

// File: tb/tb_alarm_scan_ctrl.sv
// tb_alarm_scan_ctrl: directed and randomized checks of alarm_scan_ctrl against a transaction-level model
module tb_alarm_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  pv_valid = 4'd0;
   logic [3:0]  pv_ready;
   logic [63:0] peak_data = 64'd0;
   logic [63:0] valley_data = 64'd0;
   logic [3:0]  alarm_level;
   logic        evt_valid;
   logic [1:0]  evt_ch;
   logic        evt_type;
   logic        evt_ready = 1'b1;
   int checks = 0;
   int passed = 0;
   int m_cnt [4];
   bit m_lvl [4];
   int m_rr = 0;

   alarm_scan_ctrl dut (
      .clk(clk), .rst(rst), .pv_valid(pv_valid), .pv_ready(pv_ready),
      .peak_data(peak_data), .valley_data(valley_data), .alarm_level(alarm_level),
      .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_type(evt_type), .evt_ready(evt_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] lvl_vec();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_lvl[c];
      return v;
   endfunction

   function automatic int pick(input logic [3:0] m);
      for (int k = 0; k < 4; k++) if (m[(m_rr + k) % 4]) return (m_rr + k) % 4;
      return 0;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         m_cnt[c] = 0;
         m_lvl[c] = 0;
      end
      m_rr = 0;
   endfunction

   // one accepted pair; starts and ends at a falling edge with the block idle
   task automatic pair(input logic [3:0] mask, input logic [63:0] pk, input logic [63:0] vl, input int hold);
      int g, p, v, d;
      bit lvl, ev;
      pv_valid = mask;
      peak_data = pk;
      valley_data = vl;
      evt_ready = (hold == 0);
      g = pick(mask);
      @(negedge clk);
      chk("grant", {60'd0, pv_ready}, 64'd1 << g);
      @(negedge clk);
      chk("ready_pulse", {60'd0, pv_ready}, 64'd0);
      pv_valid[g] = 1'b0;
      m_rr = (g + 1) % 4;
      p = int'(pk[g*16 +: 16]);
      v = int'(vl[g*16 +: 16]);
      d = (p >= v) ? p - v : 0;
      m_cnt[g] = (d >= 32768) ? ((m_cnt[g] >= 255) ? 255 : m_cnt[g] + 1) : 0;
      lvl = m_cnt[g] >= 10;
      ev = lvl != m_lvl[g];
      m_lvl[g] = lvl;
      @(negedge clk);
      chk("alarm_level", {60'd0, alarm_level}, {60'd0, lvl_vec()});
      chk("evt_valid", {63'd0, evt_valid}, {63'd0, ev});
      if (ev) begin
         chk("evt_ch", {62'd0, evt_ch}, 64'(g));
         chk("evt_type", {63'd0, evt_type}, {63'd0, lvl});
         for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("evt_hold_valid", {63'd0, evt_valid}, 64'd1);
            chk("evt_hold_ch", {62'd0, evt_ch}, 64'(g));
            chk("evt_hold_type", {63'd0, evt_type}, {63'd0, lvl});
            chk("evt_no_grant", {60'd0, pv_ready}, 64'd0);
         end
         evt_ready = 1'b1;
         @(negedge clk);
         chk("evt_done", {63'd0, evt_valid}, 64'd0);
      end
   endtask

   initial begin
      logic [63:0] pk, vl;
      model_reset();
      @(negedge clk);
      chk("rst_outputs", {56'd0, pv_ready, alarm_level}, 64'd0);
      chk("rst_evt", {61'd0, evt_valid, evt_ch}, 64'd0);
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("quiet", {55'd0, pv_ready, alarm_level, evt_valid}, 64'd0);
      end
      for (int i = 0; i < 10; i++) pair(4'b0001, {4{16'hC000}}, {4{16'h1000}}, 0);
      pair(4'b0001, {4{16'h5000}}, {4{16'h4000}}, 0);
      pair(4'b0100, {4{16'h1000}}, {4{16'hF000}}, 0);
      pair(4'b1000, {4{16'h1000}}, {4{16'h1000}}, 0);
      for (int i = 0; i < 5; i++) pair(4'b1111, {4{16'h2000}}, {4{16'h1000}}, 0);
      for (int i = 0; i < 9; i++) pair(4'b0010, {4{16'hF000}}, {4{16'h0100}}, 0);
      pair(4'b0001, {4{16'h2000}}, {4{16'h1000}}, 0);
      pair(4'b1010, {4{16'hF000}}, {4{16'h0100}}, 7);
      pair(4'b1000, {4{16'h2000}}, {4{16'h1000}}, 0);
      for (int i = 0; i < 9; i++) pair(4'b1000, {4{16'h8000}}, {4{16'h0000}}, 0);
      pv_valid = 4'b1000;
      peak_data = {4{16'hFFFF}};
      valley_data = 64'd0;
      evt_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_grant", {60'd0, pv_ready}, 64'h8);
      @(negedge clk);
      pv_valid = 4'd0;
      @(negedge clk);
      chk("pre_rst_evt", {61'd0, evt_valid, evt_ch}, 64'h7);
      chk("pre_rst_level", {60'd0, alarm_level}, 64'hA);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_out", {56'd0, pv_ready, alarm_level}, 64'd0);
      chk("async_rst_evt", {60'd0, evt_valid, evt_ch, evt_type}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      evt_ready = 1'b1;
      model_reset();
      @(negedge clk);
      chk("post_rst_idle", {59'd0, pv_ready, evt_valid}, 64'd0);
      for (int i = 0; i < 9; i++) pair(4'b1000, {4{16'hFFFF}}, {4{16'h0000}}, 0);
      for (int n = 0; n < 150; n++) begin
         for (int c = 0; c < 4; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 80) begin
               pk[c*16 +: 16] = 16'($urandom_range(16'hC000, 16'hFFFF));
               vl[c*16 +: 16] = 16'($urandom_range(0, 16'h3FFF));
            end else if (r < 90) begin
               vl[c*16 +: 16] = 16'($urandom_range(0, 16'h7FFF));
               pk[c*16 +: 16] = vl[c*16 +: 16] + 16'h8000 - 16'($urandom_range(0, 1));
            end else begin
               pk[c*16 +: 16] = 16'($urandom);
               vl[c*16 +: 16] = 16'($urandom);
            end
         end
         pair(4'($urandom_range(1, 15)), pk, vl, int'($urandom_range(0, 3)));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
